// File: rtl/bit_count_pkg.sv
// Shared definitions for the bit counter: default width order
// and {left,right} mode encodings.
package bit_count_pkg;

   localparam int ORDER_DEF = 3;

   typedef enum logic [1:0] {
      MODE_NONE  = 2'b00,
      MODE_CTZ   = 2'b01,
      MODE_CLZ   = 2'b10,
      MODE_TOTAL = 2'b11
   } mode_e;

   function automatic mode_e mode_of(input logic left, input logic right);
      return mode_e'({left, right});
   endfunction

endpackage

// File: rtl/bit_count_if.sv
// Operand/result bundle between the requester and the bit counter.
// Master issues operands, slave returns registered results.
interface bit_count_if
   import bit_count_pkg::*;
#(
   parameter int ORDER = ORDER_DEF
);

   localparam int W = 2 ** ORDER;

   logic             valid_i;
   logic             left;
   logic             right;
   logic             invert;
   logic [W-1:0]     data;
   logic             valid_o;
   logic [ORDER:0]   count;
   logic             zero;

   modport master (
      output valid_i, left, right, invert, data,
      input  valid_o, count, zero
   );

   modport slave (
      input  valid_i, left, right, invert, data,
      output valid_o, count, zero
   );

endinterface

// File: rtl/bit_count_cix_core.sv
// Combinational zero counter: balanced tree yielding leading,
// trailing and total zero counts, then a mode mux.
module cix_core
   import bit_count_pkg::*;
#(
   parameter int ORDER = ORDER_DEF
) (
   input  logic                  left,
   input  logic                  right,
   input  logic [2**ORDER-1:0]   x,
   output logic [ORDER:0]        count,
   output logic                  zero
);

   localparam int W = 2 ** ORDER;

   typedef logic [ORDER:0] cnt_t;

   // Heap layout: node i has lo child 2i and hi child 2i+1;
   // leaves W..2W-1 map to bits 0..W-1.
   cnt_t           lead  [1:2*W-1];
   cnt_t           trail [1:2*W-1];
   cnt_t           total [1:2*W-1];
   logic [2*W-1:1] z;

   for (genvar b = 0; b < W; b++) begin : g_leaf
      assign lead[W+b]  = {{ORDER{1'b0}}, ~x[b]};
      assign trail[W+b] = {{ORDER{1'b0}}, ~x[b]};
      assign total[W+b] = {{ORDER{1'b0}}, ~x[b]};
      assign z[W+b]     = ~x[b];
   end

   for (genvar d = 0; d < ORDER; d++) begin : g_lvl
      localparam cnt_t HALF = cnt_t'(W >> (d + 1));
      for (genvar k = 0; k < 2 ** d; k++) begin : g_node
         localparam int I  = (2 ** d) + k;
         localparam int LO = 2 * I;
         localparam int HI = 2 * I + 1;

         assign lead[I]  = z[HI] ? HALF + lead[LO]  : lead[HI];
         assign trail[I] = z[LO] ? HALF + trail[HI] : trail[LO];
         assign total[I] = total[HI] + total[LO];
         assign z[I]     = z[HI] & z[LO];
      end
   end

   always_comb begin
      count = '0;
      unique case (mode_of(left, right))
         MODE_CLZ:   count = lead[1];
         MODE_CTZ:   count = trail[1];
         MODE_TOTAL: count = total[1];
         MODE_NONE:  count = '0;
         default:    count = '0;
      endcase
   end

   assign zero = z[1];

endmodule

// File: rtl/bit_count_unit.sv
// Registered clz/ctz/popcount unit: optional operand inversion,
// combinational tree core, one result per cycle.
module bit_count_unit
   import bit_count_pkg::*;
#(
   parameter int ORDER = ORDER_DEF
) (
   input logic       clock,
   input logic       reset,
   bit_count_if.slave bus
);

   localparam int W = 2 ** ORDER;

   logic [W-1:0]   x;
   logic [ORDER:0] core_count;
   logic           core_zero;

   assign x = bus.invert ? ~bus.data : bus.data;

   cix_core #(
      .ORDER (ORDER)
   ) u_core (
      .left  (bus.left),
      .right (bus.right),
      .x     (x),
      .count (core_count),
      .zero  (core_zero)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bus.valid_o <= 1'b0;
         bus.count   <= '0;
         bus.zero    <= 1'b0;
      end else begin
         bus.valid_o <= bus.valid_i;
         if (bus.valid_i) begin
            bus.count <= core_count;
            bus.zero  <= core_zero;
         end
      end
   end

endmodule

// File: tb/tb_bit_count_unit.sv
// Directed and exhaustive checks of bit_count_unit at ORDER=3.
module tb_bit_count_unit;

   localparam int ORDER = 3;
   localparam int W     = 8;

   logic clock = 1'b0;
   logic reset = 1'b1;

   int total = 0;
   int bad   = 0;

   bit_count_if #(.ORDER(ORDER)) bus ();

   bit_count_unit #(.ORDER(ORDER)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   typedef struct {
      string      name;
      logic       left;
      logic       right;
      logic       invert;
      logic [7:0] data;
      int         exp_count;
      logic       exp_zero;
   } vec_t;

   vec_t vecs [14];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   // Loop-based reference, independent of the tree structure.
   function automatic int model_count(input logic l, input logic r,
                                      input logic inv, input logic [7:0] d);
      logic [7:0] xv;
      int n;
      xv = inv ? ~d : d;
      n = 0;
      if (l && r) begin
         for (int i = 0; i < W; i++) if (!xv[i]) n++;
      end else if (l) begin
         for (int i = W - 1; i >= 0; i--) begin
            if (xv[i]) break;
            n++;
         end
      end else if (r) begin
         for (int i = 0; i < W; i++) begin
            if (xv[i]) break;
            n++;
         end
      end
      return n;
   endfunction

   task automatic drive(input logic v, input logic l, input logic r,
                        input logic inv, input logic [7:0] d);
      bus.valid_i = v;
      bus.left    = l;
      bus.right   = r;
      bus.invert  = inv;
      bus.data    = d;
   endtask

   initial begin
      vecs[0]  = '{"clz00",   1, 0, 0, 8'h00, 8, 1};
      vecs[1]  = '{"ctz00",   0, 1, 0, 8'h00, 8, 1};
      vecs[2]  = '{"tot00",   1, 1, 0, 8'h00, 8, 1};
      vecs[3]  = '{"ctz01",   0, 1, 0, 8'h01, 0, 0};
      vecs[4]  = '{"clz01",   1, 0, 0, 8'h01, 7, 0};
      vecs[5]  = '{"ctz80",   0, 1, 0, 8'h80, 7, 0};
      vecs[6]  = '{"clz80",   1, 0, 0, 8'h80, 0, 0};
      vecs[7]  = '{"popA5",   1, 1, 1, 8'hA5, 4, 0};
      vecs[8]  = '{"popFF",   1, 1, 1, 8'hFF, 8, 1};
      vecs[9]  = '{"pop00",   1, 1, 1, 8'h00, 0, 0};
      vecs[10] = '{"none3C",  0, 0, 0, 8'h3C, 0, 0};
      vecs[11] = '{"none00",  0, 0, 0, 8'h00, 0, 1};
      vecs[12] = '{"ctz10",   0, 1, 0, 8'h10, 4, 0};
      vecs[13] = '{"clzinv",  1, 0, 1, 8'hF8, 5, 0};

      drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      #1;
      chk("rst_valid", int'(bus.valid_o), 0);
      chk("rst_count", int'(bus.count), 0);
      chk("rst_zero", int'(bus.zero), 0);

      repeat (2) @(negedge clock);
      reset = 1'b0;

      // Directed table, back-to-back.
      for (int i = 0; i < 14; i++) begin
         drive(1'b1, vecs[i].left, vecs[i].right, vecs[i].invert, vecs[i].data);
         @(negedge clock);
         chk({vecs[i].name, "_cnt"}, int'(bus.count), vecs[i].exp_count);
         chk({vecs[i].name, "_z"}, int'(bus.zero), int'(vecs[i].exp_zero));
         chk({vecs[i].name, "_v"}, int'(bus.valid_o), 1);
      end

      // Hold: valid_i low for 3 cycles with changing operand.
      drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h20);
      @(negedge clock);
      chk("hold_pre", int'(bus.count), 5);
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 1'b1, 1'b0, 1'b0, 8'(k));
         @(negedge clock);
         chk("hold_v", int'(bus.valid_o), 0);
         chk("hold_cnt", int'(bus.count), 5);
         chk("hold_z", int'(bus.zero), 0);
      end
      drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
      @(negedge clock);
      chk("resume_v", int'(bus.valid_o), 1);
      chk("resume_cnt", int'(bus.count), 8);
      chk("resume_z", int'(bus.zero), 1);

      // Exhaustive sweep over all modes and invert settings.
      for (int m = 0; m < 4; m++) begin
         for (int inv = 0; inv < 2; inv++) begin
            for (int d = 0; d < 256; d++) begin
               logic l, r, iv;
               logic [7:0] dv;
               logic [7:0] xv;
               l  = m[1];
               r  = m[0];
               iv = inv[0];
               dv = 8'(d);
               xv = iv ? ~dv : dv;
               drive(1'b1, l, r, iv, dv);
               @(negedge clock);
               chk("sweep_cnt", int'(bus.count), model_count(l, r, iv, dv));
               chk("sweep_z", int'(bus.zero), int'(xv == 8'h00));
               chk("sweep_v", int'(bus.valid_o), 1);
            end
         end
      end

      // Asynchronous reset mid-stream with valid_i held high.
      drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h01);
      @(negedge clock);
      chk("pre_rst_cnt", int'(bus.count), 7);
      #2;
      reset = 1'b1;
      #1;
      chk("mid_rst_v", int'(bus.valid_o), 0);
      chk("mid_rst_cnt", int'(bus.count), 0);
      chk("mid_rst_z", int'(bus.zero), 0);
      @(negedge clock);
      chk("in_rst_v", int'(bus.valid_o), 0);
      chk("in_rst_cnt", int'(bus.count), 0);
      reset = 1'b0;
      drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h04);
      @(negedge clock);
      chk("post_rst_v", int'(bus.valid_o), 1);
      chk("post_rst_cnt", int'(bus.count), 2);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      @(negedge clock);
      chk("post_rst_idle", int'(bus.valid_o), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
